// File: rtl/instr_sequencer.sv
// Fetch-side sequencer: owns pc/ir/run state, gates phase enables to the datapath
// and checks that controller phase strobes arrive in strict 0->1->2->3->4 order.
module instr_sequencer #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              exec,
  input  logic [4:0]        phase_bus,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [4:0]        phase_en,
  output logic              running,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    RUN      = 3'd2,
    STOPPING = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              exec_q;
  logic [2:0]        exp_phase_q, exp_phase_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic       rise;
  logic       strobe_onehot;
  logic [4:0] exp_mask;

  always_comb begin
    state_d       = state_q;
    exp_phase_d   = exp_phase_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    retired_d     = retired_q;
    rise          = exec & ~exec_q;
    strobe_onehot = (phase_bus != 5'b00000) && ((phase_bus & (phase_bus - 5'b00001)) == 5'b00000);
    exp_mask      = 5'b00001 << exp_phase_q;

    case (state_q)
      IDLE: begin
        if (rise) state_d = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_d = IDLE;
        end else if (phase_bus == 5'b00001) begin
          state_d     = RUN;
          ir_d        = imem_rdata;
          exp_phase_d = 3'd1;
        end
      end
      RUN, STOPPING: begin
        if (state_q == RUN && rise) state_d = STOPPING;
        if (phase_bus != 5'b00000) begin
          // A bad strobe wins over everything, including a phase-4 retire.
          if (!strobe_onehot || phase_bus != exp_mask) begin
            state_d = FAULT;
          end else begin
            exp_phase_d = (exp_phase_q == 3'd4) ? 3'd0 : exp_phase_q + 3'd1;
            if (phase_bus[0]) ir_d = imem_rdata;
            if (phase_bus[4]) begin
              pc_d      = branch_taken ? branch_target : pc_q + ADDR_W'(1);
              retired_d = retired_q + CNT_W'(1);
              if (halt_req || state_q == STOPPING) state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      exec_q      <= 1'b0;
      exp_phase_q <= 3'd0;
      pc_q        <= '0;
      ir_q        <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      exec_q      <= exec;
      exp_phase_q <= exp_phase_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      retired_q   <= retired_d;
    end
  end

  // STOPPING still finishes its instruction, so the datapath keeps its enables.
  assign running   = (state_q == RUN) || (state_q == STOPPING);
  assign phase_en  = phase_bus & {5{running}};
  assign fault     = (state_q == FAULT);
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus a randomized run checked
// against an instruction-level model of fetch, retire, branch, halt and stop.
module tb_instr_sequencer;

  logic        clock;
  logic        reset;
  logic        exec;
  logic [4:0]  phase_bus;
  logic [15:0] imem_rdata;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic        halt_req;
  logic [11:0] imem_addr;
  logic [11:0] pc;
  logic [15:0] ir;
  logic [4:0]  phase_en;
  logic        running;
  logic        fault;
  logic [15:0] retired;

  logic [15:0] imem [0:4095];

  int checks;
  int failures;

  logic [11:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_ret;

  instr_sequencer #(.ADDR_W(12), .DATA_W(16), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .exec         (exec),
    .phase_bus    (phase_bus),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .ir           (ir),
    .phase_en     (phase_en),
    .running      (running),
    .fault        (fault),
    .retired      (retired)
  );

  assign imem_rdata = imem[imem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; exec = 1'b0; phase_bus = '0;
    branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    m_pc = '0; m_ir = '0; m_ret = '0;
  endtask

  task automatic pulse_exec();
    exec = 1'b1; cyc();
    exec = 1'b0; cyc();
  endtask

  // One strobe cycle followed by a random idle gap (0 = back-to-back).
  task automatic strobe(input logic [4:0] pb, input logic ex, input logic br,
                        input logic [11:0] tgt, input logic h);
    exec = ex; phase_bus = pb; branch_taken = br; branch_target = tgt; halt_req = h;
    cyc();
    exec = 1'b0; phase_bus = '0; branch_taken = 1'b0; halt_req = 1'b0;
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic plain_instr(input logic br, input logic [11:0] tgt, input logic h);
    for (int p = 0; p < 5; p++)
      strobe(5'b00001 << p, 1'b0, (p == 4) ? br : 1'b0, tgt, (p == 4) ? h : 1'b0);
    m_ir  = imem[m_pc];
    m_pc  = br ? tgt : m_pc + 12'd1;
    m_ret = m_ret + 16'd1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc, ir, retired, phase_en, running, fault} !== {12'h000, 16'h0000, 16'h0000, 5'b00000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got pc=%h ir=%h ret=%h pe=%b run=%b flt=%b, want all zero",
               pc, ir, retired, phase_en, running, fault);
    end
    for (int k = 0; k < 10; k++) begin
      phase_bus = 5'b00001 << (k % 5);
      #1;
      checks++;
      if ({pc, ir, phase_en, running, fault} !== {12'h000, 16'h0000, 5'b00000, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL idle_strobe%0d: got pc=%h ir=%h pe=%b run=%b flt=%b, want zeros",
                 k, pc, ir, phase_en, running, fault);
      end
      cyc();
      phase_bus = '0;
    end
  endtask

  task automatic test_basic();
    do_reset();
    imem[0] = 16'hA001;
    imem[1] = 16'hA002;
    pulse_exec();
    phase_bus = 5'b00001;
    #1;
    checks++;
    if ({phase_en, running} !== {5'b00000, 1'b0}) begin
      failures++;
      $display("FAIL armed_no_fwd: got pe=%b run=%b, want pe=00000 run=0", phase_en, running);
    end
    cyc();
    phase_bus = '0;
    checks++;
    if ({ir, running, pc} !== {16'hA001, 1'b1, 12'h000}) begin
      failures++;
      $display("FAIL first_fetch: got ir=%h run=%b pc=%h, want ir=a001 run=1 pc=000", ir, running, pc);
    end
    strobe(5'b00010, 1'b0, 1'b0, '0, 1'b0);
    phase_bus = 5'b00100;
    #1;
    checks++;
    if (phase_en !== 5'b00100) begin
      failures++;
      $display("FAIL run_phase_en: got %b, want 00100", phase_en);
    end
    cyc();
    phase_bus = '0;
    strobe(5'b01000, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b10000, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({pc, retired} !== {12'h001, 16'd1}) begin
      failures++;
      $display("FAIL first_retire: got pc=%h ret=%0d, want pc=001 ret=1", pc, retired);
    end
    strobe(5'b00001, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (ir !== 16'hA002) begin
      failures++;
      $display("FAIL second_fetch: got ir=%h, want a002", ir);
    end
    for (int p = 1; p < 5; p++) strobe(5'b00001 << p, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({pc, retired, running} !== {12'h002, 16'd2, 1'b1}) begin
      failures++;
      $display("FAIL two_instr: got pc=%h ret=%0d run=%b, want pc=002 ret=2 run=1", pc, retired, running);
    end
    m_pc = 12'h002; m_ir = 16'hA002; m_ret = 16'd2;
  endtask

  task automatic test_branch();
    plain_instr(1'b1, 12'h3F0, 1'b0);
    checks++;
    if (pc !== 12'h3F0) begin
      failures++;
      $display("FAIL branch: got pc=%h, want 3f0", pc);
    end
    plain_instr(1'b1, 12'hFFF, 1'b0);
    plain_instr(1'b0, 12'h123, 1'b0);
    checks++;
    if ({pc, retired, ir} !== {12'h000, m_ret, imem[12'hFFF]}) begin
      failures++;
      $display("FAIL pc_wrap: got pc=%h ret=%0d ir=%h, want pc=000 ret=%0d ir=%h",
               pc, retired, ir, m_ret, imem[12'hFFF]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    pulse_exec();
    plain_instr(1'b0, '0, 1'b0);
    plain_instr(1'b0, '0, 1'b0);
    plain_instr(1'b0, '0, 1'b1);
    checks++;
    if ({pc, retired, running} !== {12'h003, 16'd3, 1'b0}) begin
      failures++;
      $display("FAIL halt: got pc=%h ret=%0d run=%b, want pc=003 ret=3 run=0", pc, retired, running);
    end
    pulse_exec();
    strobe(5'b00001, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({ir, pc, running} !== {imem[3], 12'h003, 1'b1}) begin
      failures++;
      $display("FAIL restart: got ir=%h pc=%h run=%b, want ir=%h pc=003 run=1", ir, pc, running, imem[3]);
    end
    for (int p = 1; p < 5; p++) strobe(5'b00001 << p, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({pc, retired} !== {12'h004, 16'd4}) begin
      failures++;
      $display("FAIL restart_retire: got pc=%h ret=%0d, want pc=004 ret=4", pc, retired);
    end
  endtask

  task automatic test_stop();
    strobe(5'b00001, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b00010, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b00100, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL stopping_running: got run=%b, want 1", running);
    end
    strobe(5'b01000, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b10000, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({pc, retired, running} !== {12'h005, 16'd5, 1'b0}) begin
      failures++;
      $display("FAIL stop: got pc=%h ret=%0d run=%b, want pc=005 ret=5 run=0", pc, retired, running);
    end
    pulse_exec();
    pulse_exec();
    for (int p = 0; p < 5; p++) strobe(5'b00001 << p, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({pc, retired, ir, running} !== {12'h005, 16'd5, imem[4], 1'b0}) begin
      failures++;
      $display("FAIL armed_cancel: got pc=%h ret=%0d ir=%h run=%b, want pc=005 ret=5 ir=%h run=0",
               pc, retired, ir, running, imem[4]);
    end
  endtask

  task automatic test_random();
    logic        active, stop_req, br, h;
    logic [11:0] tgt;
    int          ex_ph;
    do_reset();
    active = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!active) pulse_exec();
      ex_ph    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : -1;
      br       = ($urandom_range(0, 3) == 0);
      h        = ($urandom_range(0, 7) == 0);
      tgt      = 12'($urandom);
      stop_req = (ex_ph >= 0);
      for (int p = 0; p < 5; p++) begin
        // Branch/halt noise on non-retire strobes must be ignored.
        strobe(5'b00001 << p, (p == ex_ph), (p == 4) ? br : 1'($urandom), tgt,
               (p == 4) ? h : 1'($urandom));
        if (p == 0) begin
          m_ir = imem[m_pc];
          checks++;
          if ({ir, running} !== {m_ir, 1'b1}) begin
            failures++;
            $display("FAIL rand_fetch[%0d]: got ir=%h run=%b, want ir=%h run=1", i, ir, running, m_ir);
          end
        end
      end
      m_pc   = br ? tgt : m_pc + 12'd1;
      m_ret  = m_ret + 16'd1;
      active = !(h || stop_req);
      checks++;
      if ({pc, retired, running, fault} !== {m_pc, m_ret, active, 1'b0}) begin
        failures++;
        $display("FAIL rand_retire[%0d]: got pc=%h ret=%0d run=%b flt=%b, want pc=%h ret=%0d run=%b flt=0",
                 i, pc, retired, running, fault, m_pc, m_ret, active);
      end
    end
  endtask

  task automatic test_fault();
    do_reset();
    pulse_exec();
    strobe(5'b00001, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b00100, 1'b0, 1'b0, '0, 1'b0);
    phase_bus = 5'b00001;
    #1;
    checks++;
    if ({fault, running, phase_en} !== {1'b1, 1'b0, 5'b00000}) begin
      failures++;
      $display("FAIL skip_fault: got flt=%b run=%b pe=%b, want flt=1 run=0 pe=00000", fault, running, phase_en);
    end
    cyc();
    phase_bus = '0;
    pulse_exec();
    for (int p = 1; p < 5; p++) strobe(5'b00001 << p, 1'b0, 1'b1, 12'h777, 1'b0);
    checks++;
    if ({fault, pc, ir, retired} !== {1'b1, 12'h000, imem[0], 16'd0}) begin
      failures++;
      $display("FAIL fault_frozen: got flt=%b pc=%h ir=%h ret=%0d, want flt=1 pc=000 ir=%h ret=0",
               fault, pc, ir, retired, imem[0]);
    end
    do_reset();
    checks++;
    if (fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_clear: got flt=%b, want 0", fault);
    end
    pulse_exec();
    strobe(5'b00001, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b00010, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b00011, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({fault, running} !== {1'b1, 1'b0}) begin
      failures++;
      $display("FAIL multihot_fault: got flt=%b run=%b, want flt=1 run=0", fault, running);
    end
    do_reset();
    pulse_exec();
    for (int p = 0; p < 4; p++) strobe(5'b00001 << p, 1'b0, 1'b0, '0, 1'b0);
    strobe(5'b10001, 1'b0, 1'b1, 12'h555, 1'b0);
    checks++;
    if ({fault, pc, retired} !== {1'b1, 12'h000, 16'd0}) begin
      failures++;
      $display("FAIL phase4_fault: got flt=%b pc=%h ret=%0d, want flt=1 pc=000 ret=0", fault, pc, retired);
    end
    do_reset();
    checks++;
    if ({fault, running, pc} !== {1'b0, 1'b0, 12'h000}) begin
      failures++;
      $display("FAIL fault_reset: got flt=%b run=%b pc=%h, want 0 0 000", fault, running, pc);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; exec = 1'b0; phase_bus = '0;
    branch_taken = 1'b0; branch_target = '0; halt_req = 1'b0;
    for (int a = 0; a < 4096; a++) imem[a] = 16'($urandom);
    test_reset();
    test_basic();
    test_branch();
    test_halt();
    test_stop();
    test_random();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
